sig_control_multi: RTL and testbench

- Parametrised successor to the two-road signal controller. Drives NUM_APPR approaches with per-approach car sensors, round-robin service and programmable green/yellow/all-red durations.
- Approach 0 is the home (main) road. It rests green when no other approach has demand.
- Sits between the road-sensor synchronisers and the lamp drivers. Single clock domain.

---
 rtl/sig_control_multi.sv | 183 ++++++++++++++++++
 tb/tb_sig_control_multi.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sig_control_multi.sv
// Round-robin multi-approach signal controller; approach 0 rests green.
// Optional pedestrian walk phase is built when PED_WALK_EN is defined.
module sig_control_multi #(
    parameter int NUM_APPR = 4,
    parameter int TMR_W    = 8,
    parameter int MIN_GRN  = 6,
    parameter int MAX_GRN  = 20,
    parameter int YEL_CYC  = 3,
    parameter int RED_CYC  = 2,
    parameter int WALK_CYC = 8
) (
    input  logic                        CLOCK,
    input  logic                        CLEAR,
    input  logic [NUM_APPR-1:0]         CAR_ON_RD,
`ifdef PED_WALK_EN
    input  logic                        PED_REQ,
    output logic                        WALK,
`endif
    output logic [2*NUM_APPR-1:0]       SIG,
    output logic [$clog2(NUM_APPR)-1:0] GRN_IDX
);

    localparam int IDX_W = $clog2(NUM_APPR);

    localparam logic [1:0] GREEN   = 2'd0;
    localparam logic [1:0] YELLOW  = 2'd1;
    localparam logic [1:0] ALL_RED = 2'd2;
`ifdef PED_WALK_EN
    localparam logic [1:0] WALK_ST = 2'd3;
    localparam logic [TMR_W-1:0] T_WALK = TMR_W'(WALK_CYC - 1);
`endif

    localparam logic [TMR_W-1:0] T_MIN = TMR_W'(MIN_GRN - 1);
    localparam logic [TMR_W-1:0] T_MAX = TMR_W'(MAX_GRN - 1);
    localparam logic [TMR_W-1:0] T_YEL = TMR_W'(YEL_CYC - 1);
    localparam logic [TMR_W-1:0] T_RED = TMR_W'(RED_CYC - 1);

    if (NUM_APPR < 2 || NUM_APPR > 8 || MIN_GRN < 1 || MAX_GRN < MIN_GRN ||
        MAX_GRN >= (1 << TMR_W) || YEL_CYC < 1 || RED_CYC < 1 ||
        WALK_CYC < 1) begin : g_bad_param
        $error("sig_control_multi: illegal parameter set");
    end

    logic [1:0]          state, state_n;
    logic [IDX_W-1:0]    cur, cur_n, nxt;
    logic [TMR_W-1:0]    tmr;
    logic [NUM_APPR-1:0] req, req_n, cur_oh;
    logic                other_req;
    logic                grn_entry;
    logic                ped_dem;

    function automatic logic [2*NUM_APPR-1:0] lamps(
        input logic [1:0]       st,
        input logic [IDX_W-1:0] c
    );
        logic [2*NUM_APPR-1:0] l;
        l = '0;
        if (st == GREEN)
            l[{c, 1'b0} +: 2] = 2'd2;
        else if (st == YELLOW)
            l[{c, 1'b0} +: 2] = 2'd1;
        return l;
    endfunction

    always_comb begin
        cur_oh      = '0;
        cur_oh[cur] = 1'b1;
    end

    // First pending request after cur, wrapping; home road if none.
    always_comb begin
        logic [IDX_W-1:0] j;
        logic             found;
        j     = '0;
        found = 1'b0;
        nxt   = '0;
        for (int k = 1; k < NUM_APPR; k++) begin
            j = IDX_W'((int'(cur) + k) % NUM_APPR);
            if (!found && req[j]) begin
                nxt   = j;
                found = 1'b1;
            end
        end
    end

`ifdef PED_WALK_EN
    logic ped_pend;
    assign ped_dem = ped_pend;
`else
    assign ped_dem = 1'b0;
`endif

    assign other_req = (|(req & ~cur_oh)) | (cur != '0) | ped_dem;

    always_comb begin
        state_n = state;
        cur_n   = cur;
        case (state)
            GREEN: begin
                if (tmr >= T_MIN && other_req &&
                    (!CAR_ON_RD[cur] || tmr >= T_MAX))
                    state_n = YELLOW;
            end
            YELLOW: begin
                if (tmr == T_YEL)
                    state_n = ALL_RED;
            end
            ALL_RED: begin
                if (tmr == T_RED) begin
`ifdef PED_WALK_EN
                    if (ped_pend) begin
                        state_n = WALK_ST;
                    end else begin
                        state_n = GREEN;
                        cur_n   = nxt;
                    end
`else
                    state_n = GREEN;
                    cur_n   = nxt;
`endif
                end
            end
`ifdef PED_WALK_EN
            WALK_ST: begin
                if (tmr == T_WALK) begin
                    state_n = GREEN;
                    cur_n   = nxt;
                end
            end
`endif
            default: begin
                state_n = GREEN;
                cur_n   = '0;
            end
        endcase
    end

    assign grn_entry = (state_n == GREEN) && (state != GREEN);

    // Entering green for an approach retires its request, even if set now.
    always_comb begin
        req_n = req | (CAR_ON_RD & ~cur_oh);
        if (grn_entry)
            req_n[cur_n] = 1'b0;
    end

    always_ff @(posedge CLOCK) begin
        if (CLEAR) begin
            state   <= GREEN;
            cur     <= '0;
            tmr     <= '0;
            req     <= '0;
            SIG     <= lamps(GREEN, '0);
            GRN_IDX <= '0;
        end else begin
            state   <= state_n;
            cur     <= cur_n;
            req     <= req_n;
            SIG     <= lamps(state_n, cur_n);
            GRN_IDX <= cur_n;
            if (state_n != state)
                tmr <= '0;
            else if (tmr != '1)
                tmr <= tmr + 1'b1;
        end
    end

`ifdef PED_WALK_EN
    always_ff @(posedge CLOCK) begin
        if (CLEAR) begin
            ped_pend <= 1'b0;
            WALK     <= 1'b0;
        end else begin
            if (state_n == WALK_ST && state != WALK_ST)
                ped_pend <= 1'b0;
            else if (PED_REQ && state != WALK_ST)
                ped_pend <= 1'b1;
            WALK <= (state_n == WALK_ST);
        end
    end
`endif

endmodule

// File: tb/tb_sig_control_multi.sv
// Directed bench for sig_control_multi (4 approaches, default timing).
// Phase sequences are checked cycle by cycle at the falling edge.
module tb_sig_control_multi;

    logic       CLOCK = 1'b0;
    logic       CLEAR;
    logic [3:0] CAR_ON_RD;
    logic [7:0] SIG;
    logic [1:0] GRN_IDX;
`ifdef PED_WALK_EN
    logic       PED_REQ;
    logic       WALK;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLOCK = ~CLOCK;

    sig_control_multi #(
        .NUM_APPR(4), .TMR_W(8), .MIN_GRN(6), .MAX_GRN(20),
        .YEL_CYC(3), .RED_CYC(2), .WALK_CYC(8)
    ) dut (
        .CLOCK    (CLOCK),
        .CLEAR    (CLEAR),
        .CAR_ON_RD(CAR_ON_RD),
`ifdef PED_WALK_EN
        .PED_REQ  (PED_REQ),
        .WALK     (WALK),
`endif
        .SIG      (SIG),
        .GRN_IDX  (GRN_IDX)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, expv, $time);
        end
    endtask

    // n consecutive cycles showing lamp word s with owner idx
    task automatic ph(input string tag, input logic [7:0] s,
                      input logic [1:0] idx, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK);
            chk({tag, "_sig"}, 32'(SIG), 32'(s));
            chk({tag, "_idx"}, 32'(GRN_IDX), 32'(idx));
        end
    endtask

    initial begin
        CLEAR     = 1'b1;
        CAR_ON_RD = 4'b0000;
`ifdef PED_WALK_EN
        PED_REQ   = 1'b0;
`endif
        repeat (5) @(negedge CLOCK);
        chk("rst_sig", 32'(SIG), 32'h02);
        chk("rst_idx", 32'(GRN_IDX), 32'h0);
`ifdef PED_WALK_EN
        chk("rst_walk", 32'(WALK), 32'h0);
`endif
        CLEAR = 1'b0;
        ph("rest", 8'h02, 2'd0, 50);

        // single one-cycle request on approach 2
        CAR_ON_RD = 4'b0100;
        ph("s_g0", 8'h02, 2'd0, 1);
        CAR_ON_RD = 4'b0000;
        ph("s_y0", 8'h01, 2'd0, 3);
        ph("s_r0", 8'h00, 2'd0, 2);
        ph("s_g2", 8'h20, 2'd2, 6);
        ph("s_y2", 8'h10, 2'd2, 3);
        ph("s_r2", 8'h00, 2'd2, 2);
        ph("s_g0b", 8'h02, 2'd0, 12);

        // approach 1 held: green capped at 20 cycles, then approach 3
        CAR_ON_RD = 4'b0010;
        ph("m_g0", 8'h02, 2'd0, 1);
        ph("m_y0", 8'h01, 2'd0, 3);
        ph("m_r0", 8'h00, 2'd0, 2);
        ph("m_g1", 8'h08, 2'd1, 1);
        CAR_ON_RD = 4'b1010;
        ph("m_g1", 8'h08, 2'd1, 1);
        CAR_ON_RD = 4'b0010;
        ph("m_g1", 8'h08, 2'd1, 18);
        ph("m_y1", 8'h04, 2'd1, 1);
        CAR_ON_RD = 4'b0000;
        ph("m_y1", 8'h04, 2'd1, 2);
        ph("m_r1", 8'h00, 2'd1, 2);
        ph("m_g3", 8'h80, 2'd3, 6);
        ph("m_y3", 8'h40, 2'd3, 3);
        ph("m_r3", 8'h00, 2'd3, 2);
        ph("m_g0b", 8'h02, 2'd0, 10);

        // round robin from cur=1 over requests 0, 2, 3
        CAR_ON_RD = 4'b0010;
        ph("r_g0", 8'h02, 2'd0, 1);
        CAR_ON_RD = 4'b0000;
        ph("r_y0", 8'h01, 2'd0, 3);
        ph("r_r0", 8'h00, 2'd0, 2);
        ph("r_g1", 8'h08, 2'd1, 1);
        CAR_ON_RD = 4'b1101;
        ph("r_g1", 8'h08, 2'd1, 1);
        CAR_ON_RD = 4'b0000;
        ph("r_g1", 8'h08, 2'd1, 4);
        ph("r_y1", 8'h04, 2'd1, 3);
        ph("r_r1", 8'h00, 2'd1, 2);
        ph("r_g2", 8'h20, 2'd2, 6);
        ph("r_y2", 8'h10, 2'd2, 3);
        ph("r_r2", 8'h00, 2'd2, 2);
        ph("r_g3", 8'h80, 2'd3, 6);
        ph("r_y3", 8'h40, 2'd3, 3);
        ph("r_r3", 8'h00, 2'd3, 2);
        ph("r_g0b", 8'h02, 2'd0, 10);

        // reset on 2nd yellow of approach 2 with approach 1 pending
        CAR_ON_RD = 4'b0100;
        ph("c_g0", 8'h02, 2'd0, 1);
        CAR_ON_RD = 4'b0000;
        ph("c_y0", 8'h01, 2'd0, 3);
        ph("c_r0", 8'h00, 2'd0, 2);
        ph("c_g2", 8'h20, 2'd2, 1);
        CAR_ON_RD = 4'b0010;
        ph("c_g2", 8'h20, 2'd2, 1);
        CAR_ON_RD = 4'b0000;
        ph("c_g2", 8'h20, 2'd2, 4);
        ph("c_y2", 8'h10, 2'd2, 2);
        CLEAR = 1'b1;
        ph("c_rst", 8'h02, 2'd0, 1);
        chk("c_req", 32'(dut.req), 32'h0);
        CLEAR = 1'b0;
        ph("c_rest", 8'h02, 2'd0, 30);

`ifdef PED_WALK_EN
        // pedestrian walk from home rest
        PED_REQ = 1'b1;
        ph("p_g0", 8'h02, 2'd0, 1);
        PED_REQ = 1'b0;
        ph("p_y0", 8'h01, 2'd0, 3);
        ph("p_r0", 8'h00, 2'd0, 2);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLOCK);
            chk("p_walk", 32'(WALK), 32'h1);
            chk("p_wsig", 32'(SIG), 32'h0);
        end
        ph("p_g0b", 8'h02, 2'd0, 1);
        chk("p_walk_off", 32'(WALK), 32'h0);
        ph("p_rest", 8'h02, 2'd0, 10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
